// File: rtl/flopr_pipe.sv
// flopr_pipe: parametrised resettable register pipeline with valid/ready flow
// control and bubble collapsing. Each stage holds one word plus a valid bit.
// Optional feature macro: FLOPR_PIPE_OCC_EN adds a registered occupancy port.
module flopr_pipe #(
    parameter int unsigned W         = 8,
    parameter int unsigned DEPTH     = 3,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef FLOPR_PIPE_OCC_EN
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
`endif
    output logic [W-1:0] out_data
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    // A zero-depth pipeline has no output register to drive from.
    if (DEPTH < 1) begin : g_depth_check
        $error("flopr_pipe: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] adv_c;
    logic [W-1:0]     d_q [DEPTH];
    logic [W-1:0]     d_d [DEPTH];

    // Advance chain: a stage may load when it is empty or its successor moves.
    always_comb begin
        adv_c = '0;
        adv_c[DEPTH-1] = ~v_q[DEPTH-1] | out_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv_c[i] = ~v_q[i] | adv_c[i+1];
        end
    end

    assign in_ready  = adv_c[0] & ~flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

    // Next-state: shift advancing stages, keep data on bubbles, clear valids on flush.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (adv_c[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                d_d[0] = in_data;
            end
        end
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (adv_c[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end
        if (flush) begin
            v_d = '0;
            d_d = d_q;
        end
    end

    // Stage registers; reset discards all in-flight words immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= RESET_VAL;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

`ifdef FLOPR_PIPE_OCC_EN
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             in_fire_c;
    logic             out_fire_c;

    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;
    assign occupancy  = occ_q;

    // Occupancy tracks handshakes; both or neither leave it unchanged.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire_c && !out_fire_c) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_fire_c && out_fire_c) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Counter must always agree with the number of valid stages.
    occ_matches_valids: assert property (@(posedge clk) disable iff (reset)
        occ_q == OCC_W'($countones(v_q)));
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
// Directed bench for flopr_pipe with W=8, DEPTH=3, RESET_VAL=8'hA5.
module tb_flopr_pipe;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef FLOPR_PIPE_OCC_EN
    logic [1:0] occupancy;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    flopr_pipe #(.W(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FLOPR_PIPE_OCC_EN
        .occupancy (occupancy),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_occ(input string tag, input int exp);
`ifdef FLOPR_PIPE_OCC_EN
        chk(tag, 32'(occupancy), 32'(exp));
`else
        if (exp < 0) $display("bad occupancy expectation %s", tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push n consecutive words from base with out_ready=1 and check output timing.
    task automatic stream(input logic [7:0] base, input int n);
        out_ready = 1'b1;
        flush     = 1'b0;
        for (int c = 0; c < n + 3; c++) begin
            in_valid = (c < n);
            in_data  = base + 8'(c);
            #1;
            if (c < n) chk("strm_in_ready", 32'(in_ready), 32'(1));
            tick();
            chk("strm_out_valid", 32'(out_valid), 32'((c >= 2) && (c < n + 2)));
            if ((c >= 2) && (c < n + 2))
                chk("strm_out_data", 32'(out_data), 32'(base + 8'(c - 2)));
        end
        in_valid = 1'b0;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;

        // 1. Reset
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(8'hA5));
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk_occ("rst_occ", 0);

        // 2. Streaming 01..05
        stream(8'h01, 5);
        chk("strm_idle_data", 32'(out_data), 32'(8'h05));

        // 3. Backpressure
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(k);
            #1;
            chk("bp_accept_ready", 32'(in_ready), 32'(1));
            tick();
        end
        in_data = 8'h13;
        #1;
        chk("bp_full_ready", 32'(in_ready), 32'(0));
        tick();
        chk("bp_full_in_ready", 32'(in_ready), 32'(0));
        chk("bp_full_out_valid", 32'(out_valid), 32'(1));
        chk("bp_full_out_data", 32'(out_data), 32'(8'h10));
        chk_occ("bp_full_occ", 3);
        out_ready = 1'b1;
        #1;
        chk("bp_full_pass_ready", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_out11", 32'(out_data), 32'(8'h11));
        chk_occ("bp_occ_held", 3);
        out_ready = 1'b0;
        tick();
        chk("bp_stall_valid", 32'(out_valid), 32'(1));
        chk("bp_stall_data", 32'(out_data), 32'(8'h11));
        out_ready = 1'b1;
        tick();
        chk("bp_out12", 32'(out_data), 32'(8'h12));
        tick();
        chk("bp_out13_valid", 32'(out_valid), 32'(1));
        chk("bp_out13", 32'(out_data), 32'(8'h13));
        tick();
        chk("bp_drained", 32'(out_valid), 32'(0));

        // 4. Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h20;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h21;
        tick();
        in_valid = 1'b0;
        #1;
        chk_occ("bub_occ2", 2);
        chk("bub_in_ready", 32'(in_ready), 32'(1));
        chk("bub_out_data", 32'(out_data), 32'(8'h20));
        in_valid = 1'b1;
        in_data  = 8'h22;
        tick();
        in_valid = 1'b0;
        #1;
        chk_occ("bub_occ3", 3);
        chk("bub_full_ready", 32'(in_ready), 32'(0));

        // 5. Flush with occupancy 2
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_occ("fl_pre_occ", 2);
        chk("fl_pre_data", 32'(out_data), 32'(8'h21));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        #1;
        chk("fl_in_ready", 32'(in_ready), 32'(0));
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 32'(0));
        chk("fl_data_held", 32'(out_data), 32'(8'h21));
        chk_occ("fl_occ", 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fl_no_33", 32'(out_valid), 32'(0));
        end

        // 6. Async reset mid-stream
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(c);
            tick();
        end
        chk("ar_pre_data", 32'(out_data), 32'(8'h41));
        #3;
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'(0));
        chk("ar_out_data", 32'(out_data), 32'(8'hA5));
        chk_occ("ar_occ", 0);
        #2;
        reset = 1'b0;
        tick();
        chk("ar_post_valid", 32'(out_valid), 32'(0));
        stream(8'h50, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
